// File: rtl/game_sequencer.sv
// Frame-rate game-flow controller: intro animation, play with lives/invulnerability,
// pause, coin scoring with speed ramp, game over with persistent high score.
module game_sequencer #(
  parameter int N_COIN       = 3,
  parameter int N_FATAL      = 6,
  parameter int COUNTDOWN    = 5,
  parameter int LOGO_STEP    = 30,
  parameter int LOGO_END     = 640,
  parameter int PLAYER_START = 180,
  parameter int PLAYER_END   = 50,
  parameter int PLAYER_STEP  = 20,
  parameter int OFF_SCREEN   = 700,
  parameter int LIVES        = 3,
  parameter int INVULN       = 60,
  parameter int SCORE_W      = 16,
  parameter int SPEED_INIT   = 32,
  parameter int SPEED_MAX    = 64,
  parameter int RAMP_COINS   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic [N_COIN-1:0]  coin_hit,
  input  logic [N_FATAL-1:0] fatal_hit,
  output logic [2:0]         state,
  output logic               spawn_en,
  output logic [11:0]        logo_voffset,
  output logic [11:0]        player_voffset,
  output logic [11:0]        over_voffset,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [2:0]         lives,
  output logic [7:0]         speed,
  output logic               blink
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_COUNT  = 3'd1,
    S_LOGO   = 3'd2,
    S_SLIDE  = 3'd3,
    S_PLAY   = 3'd4,
    S_PAUSED = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  state_t st;
  logic [7:0] cnt;
  logic [7:0] ramp;
  logic [7:0] inv;
  logic       pause_q;

  function automatic logic [7:0] count_ones(input logic [N_COIN-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < N_COIN; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  logic [7:0]         coin_n;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_new;
  logic [SCORE_W-1:0] high_new;
  logic [7:0]         ramp_sum;
  logic               ramp_wrap;
  logic [7:0]         ramp_new;
  logic [7:0]         speed_new;
  logic               hit;
  logic [2:0]         lives_new;
  logic               dead;
  logic [7:0]         inv_load;
  logic [7:0]         inv_new;
  logic               pause_edge;

  assign state    = st;
  assign spawn_en = (st == S_PLAY);

  // PLAY-tick next values; the invulnerability load happens before that tick's decrement
  always_comb begin
    coin_n     = count_ones(coin_hit);
    score_sum  = {1'b0, score} + (SCORE_W + 1)'(coin_n);
    score_new  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    high_new   = (score_new > high_score) ? score_new : high_score;
    ramp_sum   = ramp + coin_n;
    ramp_wrap  = (ramp_sum >= 8'(RAMP_COINS));
    ramp_new   = ramp_wrap ? (ramp_sum - 8'(RAMP_COINS)) : ramp_sum;
    speed_new  = (ramp_wrap && (speed < 8'(SPEED_MAX))) ? (speed + 8'd1) : speed;
    hit        = (|fatal_hit) && (inv == 8'd0);
    lives_new  = hit ? (lives - 3'd1) : lives;
    dead       = hit && (lives_new == 3'd0);
    inv_load   = (hit && !dead) ? 8'(INVULN) : inv;
    inv_new    = (inv_load != 8'd0) ? (inv_load - 8'd1) : inv_load;
    pause_edge = pause && !pause_q;
  end

  // Game-flow state machine with registered outputs, advancing only on frame ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_RESET;
      cnt            <= 8'd0;
      ramp           <= 8'd0;
      inv            <= 8'd0;
      pause_q        <= 1'b0;
      logo_voffset   <= 12'd0;
      player_voffset <= 12'(PLAYER_START);
      over_voffset   <= 12'(OFF_SCREEN);
      score          <= '0;
      high_score     <= '0;
      lives          <= 3'(LIVES);
      speed          <= 8'(SPEED_INIT);
      blink          <= 1'b0;
    end else if (frame_tick) begin
      pause_q <= pause;
      case (st)
        S_RESET: begin
          cnt            <= 8'(COUNTDOWN);
          logo_voffset   <= 12'd0;
          player_voffset <= 12'(PLAYER_START);
          over_voffset   <= 12'(OFF_SCREEN);
          score          <= '0;
          lives          <= 3'(LIVES);
          speed          <= 8'(SPEED_INIT);
          blink          <= 1'b0;
          st             <= S_COUNT;
        end
        S_COUNT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             st  <= S_LOGO;
        end
        S_LOGO: begin
          if (logo_voffset < 12'(LOGO_END)) logo_voffset <= logo_voffset + 12'(LOGO_STEP);
          else                              st           <= S_SLIDE;
        end
        S_SLIDE: begin
          if (player_voffset > 12'(PLAYER_END)) player_voffset <= player_voffset - 12'(PLAYER_STEP);
          else                                  st             <= S_PLAY;
        end
        S_PLAY: begin
          score <= score_new;
          ramp  <= ramp_new;
          speed <= speed_new;
          lives <= lives_new;
          inv   <= inv_new;
          blink <= inv_new[3];
          // a game-ending hit outranks a simultaneous pause edge
          if (dead) begin
            st           <= S_OVER;
            over_voffset <= 12'd0;
            high_score   <= high_new;
          end else if (pause_edge) begin
            st <= S_PAUSED;
          end else begin
            st <= S_PLAY;
          end
        end
        S_PAUSED: begin
          if (pause_edge) st <= S_PLAY;
          else            st <= S_PAUSED;
        end
        S_OVER: begin
          if (start) st <= S_RESET;
          else       st <= S_OVER;
        end
        default: st <= S_RESET;
      endcase
    end else begin
      st <= st;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer against a rule-level reference model.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [2:0]  coin_hit = 3'd0;
  logic [5:0]  fatal_hit = 6'd0;
  logic [2:0]  state;
  logic        spawn_en;
  logic [11:0] logo_voffset, player_voffset, over_voffset;
  logic [15:0] score, high_score;
  logic [2:0]  lives;
  logic [7:0]  speed;
  logic        blink;

  game_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .coin_hit(coin_hit), .fatal_hit(fatal_hit), .state(state), .spawn_en(spawn_en),
    .logo_voffset(logo_voffset), .player_voffset(player_voffset), .over_voffset(over_voffset),
    .score(score), .high_score(high_score), .lives(lives), .speed(speed), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        sp;
    logic [11:0] lo;
    logic [11:0] pl;
    logic [11:0] ov;
    logic [15:0] sc;
    logic [15:0] hi;
    logic [2:0]  li;
    logic [7:0]  spd;
    logic        bl;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model, expressed directly in terms of the game rules
  int m_state, m_cnt, m_logo, m_player, m_over, m_score, m_high, m_lives;
  int m_speed, m_blink, m_ramp, m_inv, m_pprev;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_logo = 0; m_player = 180; m_over = 700;
    m_score = 0; m_high = 0; m_lives = 3; m_speed = 32; m_blink = 0;
    m_ramp = 0; m_inv = 0; m_pprev = 0;
  endtask

  task automatic model_tick(input logic [2:0] c, input logic [5:0] f, input bit p, input bit s);
    int n;
    bit ended;
    ended = 0;
    case (m_state)
      0: begin
        m_cnt = 5; m_logo = 0; m_player = 180; m_over = 700; m_score = 0;
        m_lives = 3; m_speed = 32; m_blink = 0; m_state = 1;
      end
      1: if (m_cnt > 0) m_cnt--; else m_state = 2;
      2: if (m_logo < 640) m_logo += 30; else m_state = 3;
      3: if (m_player > 50) m_player -= 20; else m_state = 4;
      4: begin
        n = $countones(c);
        m_score = (m_score + n > 65535) ? 65535 : m_score + n;
        m_ramp += n;
        if (m_ramp >= 10) begin
          m_ramp -= 10;
          if (m_speed < 64) m_speed++;
        end
        if (f != 0 && m_inv == 0) begin
          m_lives--;
          if (m_lives == 0) begin
            ended = 1; m_state = 6; m_over = 0;
            if (m_score > m_high) m_high = m_score;
          end else begin
            m_inv = 60;
          end
        end
        if (m_inv > 0) m_inv--;
        m_blink = (m_inv / 8) % 2;
        if (!ended && p && !m_pprev) m_state = 5;
      end
      5: if (p && !m_pprev) m_state = 4;
      6: if (s) m_state = 0;
      default: m_state = 0;
    endcase
    m_pprev = p;
  endtask

  task automatic push_expected();
    obs_t e;
    e.st = 3'(m_state); e.sp = (m_state == 4); e.lo = 12'(m_logo); e.pl = 12'(m_player);
    e.ov = 12'(m_over); e.sc = 16'(m_score); e.hi = 16'(m_high); e.li = 3'(m_lives);
    e.spd = 8'(m_speed); e.bl = 1'(m_blink);
    exp_q.push_back(e);
  endtask

  // one clock cycle of stimulus; expectation for the following edge goes to the scoreboard
  task automatic cyc(input bit tk, input bit rs, input logic [2:0] c, input logic [5:0] f,
                     input bit p, input bit s);
    @(negedge clk);
    frame_tick = tk; rst = rs; coin_hit = c; fatal_hit = f; pause = p; start = s;
    if (rs) model_reset();
    else if (tk) model_tick(c, f, p, s);
    push_expected();
  endtask

  task automatic tick(input logic [2:0] c, input logic [5:0] f, input bit p, input bit s);
    cyc(1'b1, 1'b0, c, f, p, s);
  endtask

  task automatic idle_random();
    cyc(1'b0, 1'b0, 3'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // monitor: every cycle the DUT presents a new output set, compare against the scoreboard
  obs_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{state, spawn_en, logo_voffset, player_voffset, over_voffset,
                score, high_score, lives, speed, blink};
      n_checks++;
      if (mon_a === mon_e) n_pass++;
      else $display("FAIL outputs t=%0t: actual st=%0d sp=%0d lo=%0d pl=%0d ov=%0d sc=%0d hi=%0d li=%0d spd=%0d bl=%0d required st=%0d sp=%0d lo=%0d pl=%0d ov=%0d sc=%0d hi=%0d li=%0d spd=%0d bl=%0d",
                    $time, mon_a.st, mon_a.sp, mon_a.lo, mon_a.pl, mon_a.ov, mon_a.sc, mon_a.hi,
                    mon_a.li, mon_a.spd, mon_a.bl, mon_e.st, mon_e.sp, mon_e.lo, mon_e.pl,
                    mon_e.ov, mon_e.sc, mon_e.hi, mon_e.li, mon_e.spd, mon_e.bl);
    end
  end

  task automatic run_intro();
    for (int k = 0; k < 400 && m_state != 4; k++) begin
      if ($urandom_range(0, 3) == 0) idle_random();
      else tick(3'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
    end
    tick(3'd0, 6'd0, 1'b0, 1'b0);
  endtask

  int saved_high;

  initial begin
    model_reset();
    repeat (3) cyc(1'b0, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    settle();
    chk("reset_state", int'(state), 0);
    chk("reset_player", int'(player_voffset), 180);
    chk("reset_over", int'(over_voffset), 700);

    // intro through to PLAY
    run_intro();
    settle();
    chk("intro_play", int'(state), 4);
    chk("intro_logo", int'(logo_voffset), 660);
    chk("intro_player", int'(player_voffset), 40);
    chk("intro_spawn", int'(spawn_en), 1);

    // scoring and ramp (one zero-coin tick already happened in PLAY)
    repeat (4) tick(3'b111, 6'd0, 1'b0, 1'b0);
    settle();
    chk("score_12", int'(score), 12);
    chk("speed_33", int'(speed), 33);

    // pause: inputs ignored while paused
    tick(3'd0, 6'd0, 1'b1, 1'b0);
    settle();
    chk("paused_state", int'(state), 5);
    chk("paused_spawn", int'(spawn_en), 0);
    repeat (4) begin
      tick(3'($urandom_range(1, 7)), 6'($urandom_range(1, 63)), 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_random();
    end
    settle();
    chk("paused_score", int'(score), 12);
    chk("paused_lives", int'(lives), 3);
    tick(3'd0, 6'd0, 1'b0, 1'b0);
    tick(3'd0, 6'd0, 1'b1, 1'b0);
    settle();
    chk("resume_play", int'(state), 4);

    // lives and invulnerability window
    tick(3'd0, 6'b000100, 1'b1, 1'b0);
    settle();
    chk("hit1_lives", int'(lives), 2);
    chk("hit1_blink", int'(blink), 1);
    repeat (29) tick(3'($urandom), 6'd0, 1'b1, 1'b0);
    tick(3'd0, 6'b100000, 1'b1, 1'b0);
    settle();
    chk("hit_ignored", int'(lives), 2);
    repeat (29) tick(3'($urandom), 6'd0, 1'b1, 1'b0);
    tick(3'd0, 6'b000001, 1'b1, 1'b0);
    settle();
    chk("hit2_lives", int'(lives), 1);

    // drain invulnerability, then final hit together with a pause edge
    for (int k = 0; k < 400 && m_state != 6; k++) begin
      if (m_state == 5) begin
        tick(3'd0, 6'd0, 1'b0, 1'b0);
        tick(3'd0, 6'd0, 1'b1, 1'b0);
      end else if (m_inv != 0) begin
        if ($urandom_range(0, 3) == 0) idle_random();
        tick(3'($urandom), 6'($urandom), 1'b0, 1'b0);
      end else begin
        tick(3'd0, 6'd0, 1'b0, 1'b0);
        tick(3'($urandom), 6'($urandom_range(1, 63)), 1'b1, 1'b0);
      end
    end
    settle();
    chk("over_state", int'(state), 6);
    chk("over_voffset", int'(over_voffset), 0);
    chk("over_high", int'(high_score), int'(score));
    saved_high = m_high;

    // restart keeps the high score
    repeat (3) tick(3'($urandom), 6'($urandom), 1'b0, 1'b0);
    idle_random();
    tick(3'd0, 6'd0, 1'b0, 1'b1);
    settle();
    chk("restart_reset", int'(state), 0);
    tick(3'd0, 6'd0, 1'b0, 1'b0);
    settle();
    chk("restart_count", int'(state), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_lives", int'(lives), 3);
    chk("restart_high", int'(high_score), saved_high);

    // second intro, then run score into saturation
    run_intro();
    for (int k = 0; k < 30000 && m_score < 65535; k++) tick(3'b111, 6'd0, 1'b0, 1'b0);
    repeat (2) tick(3'b011, 6'd0, 1'b0, 1'b0);
    settle();
    chk("score_sat", int'(score), 65535);
    chk("speed_sat", int'(speed), 64);

    // reset while paused clears everything, including the high score
    tick(3'd0, 6'd0, 1'b1, 1'b0);
    settle();
    chk("paused_again", int'(state), 5);
    cyc(1'b1, 1'b1, 3'b111, 6'b111111, 1'b1, 1'b1);
    settle();
    chk("rst_state", int'(state), 0);
    chk("rst_high", int'(high_score), 0);
    chk("rst_speed", int'(speed), 32);
    repeat (5) tick(3'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
